signed_bcd_converter: RTL and testbench

- Sequential converter directly downstream of the arithmetic stage (add/subtract).
- Takes the n-bit two's-complement result and produces a sign flag plus packed BCD digits for the seven-segment display driver.
- Uses multi-cycle shift-and-add-3 (double dabble), one bit per clock, with a start/done handshake. This keeps LUT cost low next to the combinational arithmetic.

---
 rtl/signed_bcd_converter_if.sv | 25 ++
 rtl/signed_bcd_converter.sv | 141 ++++++++++++++
 tb/tb_signed_bcd_converter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/signed_bcd_converter_if.sv
// Handshake and result bundle between the arithmetic stage, the signed BCD
// converter and the seven-segment display driver.
interface signed_bcd_converter_if #(
  parameter int unsigned n      = 6,
  parameter int unsigned DIGITS = 2
);
  logic                  start;
  logic [n-1:0]          value;
  logic                  busy;
  logic                  done;
  logic                  negative;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, value,
    input  busy, done, negative, bcd, overflow, blank
  );

  modport slave (
    input  start, value,
    output busy, done, negative, bcd, overflow, blank
  );
endinterface

// File: rtl/signed_bcd_converter.sv
// Two's-complement to sign + packed BCD converter using bit-serial double dabble.
// Define LEADING_ZERO_BLANK_EN to generate the leading-zero blank mask.
module signed_bcd_converter #(
  parameter int unsigned n      = 6,
  parameter int unsigned DIGITS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  signed_bcd_converter_if.slave  bus
);

  localparam int unsigned SW = 4 * (DIGITS + 1);
  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(n + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e         state_q, state_d;
  logic [SW-1:0]  scr_q, scr_d;
  logic [n-1:0]   bin_q, bin_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sign_q, sign_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           neg_q, neg_d;
  logic           ovf_q, ovf_d;
  logic [BW-1:0]  bcd_q, bcd_d;
`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              zero_run;
`endif

  logic [SW-1:0]  scr_adj_c;
  logic [n-1:0]   mag_c;
  logic           ovf_c;

  // Most-negative input wraps to 2^(n-1), which is the correct unsigned magnitude
  assign mag_c = bus.value[n-1] ? (n'(~bus.value) + n'(1)) : bus.value;
  assign ovf_c = |scr_q[SW-1 -: 4];

  // Add-3 correction applied to every scratch digit before each shift
  always_comb begin
    for (int i = 0; i < int'(DIGITS) + 1; i++) begin
      scr_adj_c[i*4 +: 4] = (scr_q[i*4 +: 4] >= 4'd5) ? scr_q[i*4 +: 4] + 4'd3
                                                      : scr_q[i*4 +: 4];
    end
  end

  always_comb begin
    state_d = state_q;
    scr_d   = scr_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    done_d  = 1'b0;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;
`ifdef LEADING_ZERO_BLANK_EN
    blank_d  = blank_q;
    zero_run = 1'b1;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sign_d  = bus.value[n-1];
          bin_d   = mag_c;
          scr_d   = '0;
          cnt_d   = CW'(n);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, bin_d} = {scr_adj_c[SW-2:0], bin_q, 1'b0};
        cnt_d          = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        neg_d   = sign_q;
        ovf_d   = ovf_c;
        bcd_d   = ovf_c ? {DIGITS{4'h9}} : scr_q[BW-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef LEADING_ZERO_BLANK_EN
        // A digit blanks only if it and every more-significant digit is zero
        blank_d = '0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
          zero_run   = zero_run & (scr_q[i*4 +: 4] == 4'd0);
          blank_d[i] = zero_run & ~ovf_c;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      scr_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
`ifdef LEADING_ZERO_BLANK_EN
      blank_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      scr_q   <= scr_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
`ifdef LEADING_ZERO_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.negative = neg_q;
  assign bus.overflow = ovf_q;
  assign bus.bcd      = bcd_q;
`ifdef LEADING_ZERO_BLANK_EN
  assign bus.blank    = blank_q;
`else
  assign bus.blank    = '0;
`endif

endmodule

// File: tb/tb_signed_bcd_converter.sv
// Scoreboard bench for signed_bcd_converter: n=6 and n=8 instances, both DIGITS=2.
module tb_signed_bcd_converter;

  typedef struct {
    logic       neg;
    logic [7:0] bcd;
    logic       ovf;
    logic [1:0] blank;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   passed = 0;
  exp_t q6[$];
  exp_t q8[$];

  signed_bcd_converter_if #(.n(6), .DIGITS(2)) bus6 ();
  signed_bcd_converter_if #(.n(8), .DIGITS(2)) bus8 ();

  signed_bcd_converter #(.n(6), .DIGITS(2)) dut6 (.clk(clk), .rst(rst), .bus(bus6));
  signed_bcd_converter #(.n(8), .DIGITS(2)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  // Reference: plain decimal arithmetic on the signed integer value
  function automatic exp_t model(input int v);
    exp_t r;
    int   mag;
    mag     = (v < 0) ? -v : v;
    r.neg   = (v < 0);
    r.ovf   = (mag >= 100);
    r.bcd   = r.ovf ? 8'h99 : 8'(((mag / 10) * 16) + (mag % 10));
    r.blank = 2'b00;
`ifdef LEADING_ZERO_BLANK_EN
    r.blank[1] = !r.ovf && (mag < 10);
`endif
    return r;
  endfunction

  task automatic cmp_result(input string tag, input exp_t e, input logic neg,
                            input logic [7:0] bcd, input logic ovf, input logic [1:0] blank);
    check({tag, "_negative"}, int'(neg), int'(e.neg));
    check({tag, "_bcd"}, int'(bcd), int'(e.bcd));
    check({tag, "_overflow"}, int'(ovf), int'(e.ovf));
    check({tag, "_blank"}, int'(blank), int'(e.blank));
  endtask

  always @(negedge clk) begin : mon6
    exp_t e;
    if (bus6.done) begin
      if (q6.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done6: got done=1, expected no pending result at %0t", $time);
      end else begin
        e = q6.pop_front();
        cmp_result("res6", e, bus6.negative, bus6.bcd, bus6.overflow, bus6.blank);
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (bus8.done) begin
      if (q8.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done8: got done=1, expected no pending result at %0t", $time);
      end else begin
        e = q8.pop_front();
        cmp_result("res8", e, bus8.negative, bus8.bcd, bus8.overflow, bus8.blank);
      end
    end
  end

  // Issue one n=6 conversion from a negedge; returns at the negedge where done is seen
  task automatic run6(input int v);
    int j, busy_cnt, done_j;
    bus6.value = 6'(v);
    bus6.start = 1'b1;
    q6.push_back(model(v));
    @(posedge clk);
    #1 bus6.start = 1'b0;
    j = 0; busy_cnt = 0; done_j = -1;
    while (j < 40) begin
      @(negedge clk);
      if (bus6.busy) busy_cnt++;
      if (bus6.done) begin done_j = j; break; end
      @(posedge clk);
      j++;
    end
    check("latency6", done_j, 7);
    check("busy_cycles6", busy_cnt, 6);
  endtask

  task automatic run8(input int v);
    int j, busy_cnt, done_j;
    bus8.value = 8'(v);
    bus8.start = 1'b1;
    q8.push_back(model(v));
    @(posedge clk);
    #1 bus8.start = 1'b0;
    j = 0; busy_cnt = 0; done_j = -1;
    while (j < 40) begin
      @(negedge clk);
      if (bus8.busy) busy_cnt++;
      if (bus8.done) begin done_j = j; break; end
      @(posedge clk);
      j++;
    end
    check("latency8", done_j, 9);
    check("busy_cycles8", busy_cnt, 8);
  endtask

  initial begin : stim
    int d1, d2, ndone;
    bus6.start = 1'b0; bus6.value = '0;
    bus8.start = 1'b0; bus8.value = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", int'(bus6.busy), 0);
    check("rst_done", int'(bus6.done), 0);
    check("rst_bcd", int'(bus6.bcd), 0);
    check("rst_negative", int'(bus6.negative), 0);
    check("rst_overflow", int'(bus6.overflow), 0);
    check("rst_blank", int'(bus6.blank), 0);

    // Directed values, back-to-back
    run6(-5);
    run6(-32);
    run6(31);
    run6(0);
    run6(5);
    run6(-1);
    run6(10);

    // start held high through the conversion: one result, then a back-to-back restart
    bus6.value = 6'(-5);
    bus6.start = 1'b1;
    q6.push_back(model(-5));
    q6.push_back(model(31));
    @(posedge clk);
    #1 bus6.value = 6'(31);
    d1 = -1; d2 = -1; ndone = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (j == 8) bus6.start = 1'b0;
      if (bus6.done) begin
        ndone++;
        if (d1 < 0) d1 = j; else d2 = j;
      end
      @(posedge clk);
    end
    @(negedge clk);
    check("held_done_count", ndone, 2);
    check("held_first_done", d1, 7);
    check("held_second_done", d2, 15);

    // Reset mid-conversion
    run6(-5);
    bus6.value = 6'(31);
    bus6.start = 1'b1;
    @(posedge clk);
    #1 bus6.start = 1'b0;
    repeat (2) begin @(negedge clk); @(posedge clk); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(bus6.busy), 0);
    check("abort_done", int'(bus6.done), 0);
    check("abort_bcd", int'(bus6.bcd), 0);
    check("abort_negative", int'(bus6.negative), 0);
    ndone = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (bus6.done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run6(-5);

    // Randomized n=6
    for (int k = 0; k < 30; k++) begin
      run6(int'($urandom_range(0, 63)) - 32);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // n=8: overflow boundaries plus random
    run8(100);
    run8(-128);
    run8(99);
    run8(-99);
    run8(127);
    for (int k = 0; k < 20; k++) begin
      run8(int'($urandom_range(0, 255)) - 128);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("queue6_drained", q6.size(), 0);
    check("queue8_drained", q8.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
